// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the exhaustive truth-table sweeper.
//   sweep_state_t : sweep FSM states (IDLE, SETTLE, FINISH)
//   N_IN_MAX      : largest supported number of DUT inputs
//   HOLD_MIN      : smallest supported per-vector hold time in cycles
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } sweep_state_t;

  localparam int N_IN_MAX = 8;
  localparam int HOLD_MIN = 1;

endpackage

// File: rtl/tt_sweeper_hold_timer.sv
// tt_hold_timer: loadable down-counter that saturates at zero.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val (has priority over counting)
//   load_val   : reload value
//   en         : count down by one while non-zero
//   expire     : high while the count is zero
module tt_hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;

  // Reload beats counting so a new vector always gets its full hold time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/tt_sweeper.sv
// tt_sweeper: walks every input vector 0 .. 2**N_IN-1, holds each for HOLD
// cycles, samples dut_out on the last hold cycle and compares it against
// the EXPECT truth table.
// Parameters: N_IN (1..8), HOLD (>=1), EXPECT (bit i = f(i)).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a sweep (only looked at in IDLE)
//   dut_out        : DUT response to stim
//   stim           : vector driven to the DUT (MSB = input A)
//   busy           : sweep in progress
//   done           : one-cycle pulse at the end of a sweep
//   pass           : last sweep had no mismatches
//   err_cnt        : mismatch count
//   first_err_vld  : at least one mismatch seen
//   first_err_idx  : index of the first mismatch
//   observed       : captured DUT truth table (only with TT_SWEEP_CAPTURE_EN)
module tt_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                 N_IN   = 4,
  parameter int                 HOLD   = 20,
  parameter logic [2**N_IN-1:0] EXPECT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dut_out,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic              first_err_vld,
  output logic [N_IN-1:0]   first_err_idx
`ifdef TT_SWEEP_CAPTURE_EN
  ,
  output logic [2**N_IN-1:0] observed
`endif
);

  localparam int              TW     = $clog2(HOLD) + 1;
  localparam logic [TW-1:0]   RELOAD = TW'(HOLD - 1);
  localparam logic [N_IN-1:0] LAST   = '1;

  if ((N_IN < 1) || (N_IN > N_IN_MAX)) begin : g_bad_n_in
    $error("tt_sweeper: N_IN out of range");
  end
  if (HOLD < HOLD_MIN) begin : g_bad_hold
    $error("tt_sweeper: HOLD below minimum");
  end

  sweep_state_t state, state_next;
  logic         sample;
  logic         expire;
  logic         mismatch;
  logic         timer_load;
  logic         kick;

  assign kick       = (state == IDLE) && start;
  assign mismatch   = (dut_out != EXPECT[stim]);
  assign timer_load = kick || (sample && (stim != LAST));

  tt_hold_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (RELOAD),
    .en       (state == SETTLE),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A vector is sampled on the cycle its hold timer reads zero; the last
  // sample moves the sweep to FINISH where done is pulsed.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (expire) begin
          sample = 1'b1;
          if (stim == LAST) state_next = FINISH;
        end
      end
      FINISH: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // pass is computed on the final sample edge, from the count including
  // that last comparison, so it is already valid during the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim          <= '0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if (kick) begin
      stim          <= '0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if (sample) begin
      if (mismatch) begin
        err_cnt <= err_cnt + (N_IN+1)'(1);
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= stim;
        end
      end
      if (stim == LAST) begin
        pass <= !mismatch && (err_cnt == '0);
      end else begin
        stim <= stim + N_IN'(1);
      end
    end else if (state == FINISH) begin
      stim <= '0;
    end
  end

`ifdef TT_SWEEP_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      observed <= '0;
    end else if (kick) begin
      observed <= '0;
    end else if (sample) begin
      observed[stim] <= dut_out;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweeper.sv
// Self-checking bench for tt_sweeper. Three instances cover the parameter
// sets of interest: dut_a (N_IN=4, HOLD=2, EXPECT=A5C3, selectable DUT
// function), dut_b (EXPECT=0101, stuck-at-0 DUT) and dut_c (N_IN=2,
// HOLD=1, XOR DUT). Builds with or without TT_SWEEP_CAPTURE_EN.
module tb_tt_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v = 1'b0;
  int   sel = 0;
  logic [15:0] func_a = 16'hA5C3;

  int check_cnt = 0;
  int pass_cnt = 0;
  int stim_log [0:63];
  logic busy_log [0:63];

  always #5 clk = ~clk;

  logic start_a, start_b, start_c;
  assign start_a = start_v && (sel == 0);
  assign start_b = start_v && (sel == 1);
  assign start_c = start_v && (sel == 2);

  logic [3:0] stim_a, stim_b, fidx_a, fidx_b;
  logic [1:0] stim_c, fidx_c;
  logic [4:0] err_a, err_b;
  logic [2:0] err_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic pass_a, pass_b, pass_c, fvld_a, fvld_b, fvld_c;
  wire  dut_out_a = func_a[stim_a];
  wire  dut_out_b = 1'b0;
  wire  dut_out_c = stim_c[1] ^ stim_c[0];
`ifdef TT_SWEEP_CAPTURE_EN
  logic [15:0] observed_a, observed_b;
  logic [3:0]  observed_c;
`endif

  tt_sweeper #(.N_IN(4), .HOLD(2), .EXPECT(16'hA5C3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_err_vld(fvld_a), .first_err_idx(fidx_a)
`ifdef TT_SWEEP_CAPTURE_EN
    , .observed(observed_a)
`endif
  );

  tt_sweeper #(.N_IN(4), .HOLD(2), .EXPECT(16'h0101)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_err_vld(fvld_b), .first_err_idx(fidx_b)
`ifdef TT_SWEEP_CAPTURE_EN
    , .observed(observed_b)
`endif
  );

  tt_sweeper #(.N_IN(2), .HOLD(1), .EXPECT(4'b0110)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dut_out(dut_out_c),
    .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_cnt(err_c), .first_err_vld(fvld_c), .first_err_idx(fidx_c)
`ifdef TT_SWEEP_CAPTURE_EN
    , .observed(observed_c)
`endif
  );

  // Common view of whichever instance is currently selected.
  logic [3:0] v_stim, v_fidx;
  logic [4:0] v_err;
  logic v_busy, v_done, v_pass, v_fvld;
  always_comb begin
    v_stim = '0; v_fidx = '0; v_err = '0;
    v_busy = 1'b0; v_done = 1'b0; v_pass = 1'b0; v_fvld = 1'b0;
    case (sel)
      0: begin
        v_stim = stim_a; v_fidx = fidx_a; v_err = err_a;
        v_busy = busy_a; v_done = done_a; v_pass = pass_a; v_fvld = fvld_a;
      end
      1: begin
        v_stim = stim_b; v_fidx = fidx_b; v_err = err_b;
        v_busy = busy_b; v_done = done_b; v_pass = pass_b; v_fvld = fvld_b;
      end
      default: begin
        v_stim = {2'b00, stim_c}; v_fidx = {2'b00, fidx_c}; v_err = {2'b00, err_c};
        v_busy = busy_c; v_done = done_c; v_pass = pass_c; v_fvld = fvld_c;
      end
    endcase
  end

  // Count one comparison and report it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Start a sweep on instance s, then watch it for 'budget' cycles. Cycle 1
  // is the one after the start edge. start is re-pulsed on cycles r1/r2.
  task automatic applyStimulus(input int s, input int r1, input int r2, input int budget,
                               output int done_cycle, output int done_count);
    done_cycle = -1;
    done_count = 0;
    sel = s;
    @(negedge clk);
    start_v = 1'b1;
    @(posedge clk);
    #1 start_v = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start_v = (c == r1) || (c == r2);
      stim_log[c] = int'(v_stim);
      busy_log[c] = v_busy;
      if (v_done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
    end
    start_v = 1'b0;
  endtask

  initial begin
    int dc, dn, waited;
    #1;
    checkOutput("reset_stim", v_stim, 0);
    checkOutput("reset_busy", v_busy, 0);
    checkOutput("reset_done", v_done, 0);
    checkOutput("reset_err", v_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Matching DUT: clean pass, done on cycle 33, busy drops on 34.
    applyStimulus(0, 0, 0, 36, dc, dn);
    checkOutput("t1_done_cycle", dc, 33);
    checkOutput("t1_done_count", dn, 1);
    checkOutput("t1_pass", v_pass, 1);
    checkOutput("t1_err_cnt", v_err, 0);
    checkOutput("t1_first_vld", v_fvld, 0);
    checkOutput("t1_busy_33", busy_log[33], 1);
    checkOutput("t1_busy_34", busy_log[34], 0);
    checkOutput("t1_stim_2", stim_log[2], 0);
    checkOutput("t1_stim_3", stim_log[3], 1);
    checkOutput("t1_stim_32", stim_log[32], 15);
    checkOutput("t1_stim_idle", v_stim, 0);
`ifdef TT_SWEEP_CAPTURE_EN
    checkOutput("t1_observed", observed_a, 32'h0000A5C3);
`endif

    // Restarts mid-sweep are ignored.
    applyStimulus(0, 5, 20, 36, dc, dn);
    checkOutput("t3_done_cycle", dc, 33);
    checkOutput("t3_done_count", dn, 1);
    checkOutput("t3_pass", v_pass, 1);

    // Stuck-at-0 against 0101: mismatches at 0 and 8.
    applyStimulus(1, 0, 0, 36, dc, dn);
    checkOutput("t2_done_cycle", dc, 33);
    checkOutput("t2_err_cnt", v_err, 2);
    checkOutput("t2_first_idx", v_fidx, 0);
    checkOutput("t2_first_vld", v_fvld, 1);
    checkOutput("t2_pass", v_pass, 0);
`ifdef TT_SWEEP_CAPTURE_EN
    checkOutput("t2_observed", observed_b, 0);
`endif

    // Two-input XOR with HOLD=1.
    applyStimulus(2, 0, 0, 8, dc, dn);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("t5_stim_%0d", k + 1), stim_log[k + 1], k);
    checkOutput("t5_done_cycle", dc, 5);
    checkOutput("t5_pass", v_pass, 1);
    checkOutput("t5_busy_6", busy_log[6], 0);
`ifdef TT_SWEEP_CAPTURE_EN
    checkOutput("t5_observed", observed_c, 4'b0110);
`endif

    // DUT implementing 3C5A against A5C3: xor 9999 -> 8 mismatches, first at 0.
    func_a = 16'h3C5A;
    applyStimulus(0, 0, 0, 36, dc, dn);
    checkOutput("t6_done_cycle", dc, 33);
    checkOutput("t6_err_cnt", v_err, 8);
    checkOutput("t6_first_idx", v_fidx, 0);
    checkOutput("t6_first_vld", v_fvld, 1);
    checkOutput("t6_pass", v_pass, 0);
`ifdef TT_SWEEP_CAPTURE_EN
    checkOutput("t6_observed", observed_a, 32'h00003C5A);
`endif

    // Asynchronous reset while stim==7 (err_cnt already non-zero here).
    sel = 0;
    @(negedge clk);
    start_v = 1'b1;
    @(posedge clk);
    #1 start_v = 1'b0;
    waited = 0;
    while ((v_stim != 4'd7) && (waited < 40)) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t4_reached_stim7", (v_stim == 4'd7), 1);
    checkOutput("t4_err_before", v_err, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4_rst_stim", v_stim, 0);
    checkOutput("t4_rst_busy", v_busy, 0);
    checkOutput("t4_rst_err", v_err, 0);
    checkOutput("t4_rst_first_vld", v_fvld, 0);
    checkOutput("t4_rst_first_idx", v_fidx, 0);
    checkOutput("t4_rst_pass", v_pass, 0);
`ifdef TT_SWEEP_CAPTURE_EN
    checkOutput("t4_rst_observed", observed_a, 0);
`endif
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (v_done) dn++;
    end
    checkOutput("t4_no_done", dn, 0);
    func_a = 16'hA5C3;
    applyStimulus(0, 0, 0, 36, dc, dn);
    checkOutput("t4_done_cycle", dc, 33);
    checkOutput("t4_pass", v_pass, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
